// File: rtl/alu_seq16.sv
// alu_seq16: runs one 16-bit operation as two byte issues on an attached
// 8-bit ALU whose output is registered. The low byte is issued in LO and the
// high byte in HI. The carry into the high byte (c8) and the final 16-bit
// carry-out are computed here, because the ALU has no usable carry output.
// Optional build macro: ALU_SEQ_CHECK_EN. When it is defined, the block
// predicts each returned byte and raises a sticky err on any mismatch.
`timescale 1ns/1ps
module alu_seq16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_s,
  output logic        alu_cin,
  input  logic [7:0]  alu_data,
  output logic [15:0] result,
  output logic        cout,
  output logic        busy,
  output logic        done
`ifdef ALU_SEQ_CHECK_EN
  ,output logic       err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, FIN = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] x_q, y_q;
  logic        cin_q;
  logic [15:0] result_q;
  logic        cout_q, done_q;
  logic [15:0] addend;
  logic [16:0] sum17;
  logic [8:0]  lo9;
  logic        c8;

  // Arithmetic addend chosen by op[1:0]: 0, y, ~y or all ones
  always_comb begin
    addend = 16'h0000;
    case (op_q[1:0])
      2'd0: addend = 16'h0000;
      2'd1: addend = y_q;
      2'd2: addend = ~y_q;
      2'd3: addend = 16'hFFFF;
      default: addend = 16'h0000;
    endcase
  end

  assign sum17 = {1'b0, x_q} + {1'b0, addend} + {16'h0000, cin_q};
  assign lo9   = {1'b0, x_q[7:0]} + {1'b0, addend[7:0]} + {8'h00, cin_q};
  assign c8    = lo9[8];

  // State register; reset discards any in-flight command
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: only IDLE waits, every other state advances unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: low byte in LO, high byte with the local carry in HI, 0 otherwise
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_s   = 3'b000;
    alu_cin = 1'b0;
    case (state_q)
      LO: begin
        alu_a   = x_q[7:0];
        alu_b   = y_q[7:0];
        alu_s   = op_q;
        alu_cin = cin_q;
      end
      HI: begin
        alu_a   = x_q[15:8];
        alu_b   = y_q[15:8];
        alu_s   = op_q;
        alu_cin = op_q[2] ? cin_q : c8;
      end
      default: ;
    endcase
  end

  // Operand latch and result assembly; done pulses in the cycle after FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 3'b000;
      x_q      <= 16'h0000;
      y_q      <= 16'h0000;
      cin_q    <= 1'b0;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q  <= op;
          x_q   <= x;
          y_q   <= y;
          cin_q <= cin;
        end
        HI:  result_q[7:0] <= alu_data;
        FIN: begin
          result_q[15:8] <= alu_data;
          cout_q         <= op_q[2] ? 1'b0 : sum17[16];
          done_q         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

`ifdef ALU_SEQ_CHECK_EN
  logic [15:0] logic16, exp16;
  logic        err_q;

  // Predicted 16-bit value; the byte halves are what the ALU should return
  always_comb begin
    logic16 = 16'h0000;
    case ({op_q[0], cin_q})
      2'b00: logic16 = x_q & y_q;
      2'b01: logic16 = x_q | y_q;
      2'b10: logic16 = x_q ^ y_q;
      2'b11: logic16 = ~x_q;
      default: logic16 = 16'h0000;
    endcase
    exp16 = op_q[2] ? logic16 : sum17[15:0];
  end

  // Sticky mismatch flag, compared at both capture edges
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (state_q == HI  && alu_data != exp16[7:0])  err_q <= 1'b1;
    else if (state_q == FIN && alu_data != exp16[15:8]) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_sum;
  assign unused_sum = ^{sum17[15:0], lo9[7:0]};
`endif

endmodule

// File: tb/tb_alu_seq16.sv
`timescale 1ns/1ps
module tb_alu_seq16;
  logic        clk = 1'b0;
  logic        rst, start, cin, alu_cin, cout, busy, done;
  logic [2:0]  op, alu_s;
  logic [15:0] x, y, result;
  logic [7:0]  alu_a, alu_b, alu_data;
  logic        corrupt = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;

  alu_seq16 dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_data(alu_data), .result(result), .cout(cout), .busy(busy), .done(done)
`ifdef ALU_SEQ_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Byte ALU model: registered result, optional corruption of one capture
  function automatic logic [7:0] alu8(input logic [7:0] a, b, input logic [2:0] s, input logic c);
    logic [7:0] ad;
    if (!s[2]) begin
      case (s[1:0])
        2'd0: ad = 8'h00;
        2'd1: ad = b;
        2'd2: ad = ~b;
        default: ad = 8'hFF;
      endcase
      return a + ad + {7'b0, c};
    end
    case ({s[0], c})
      2'b00: return a & b;
      2'b01: return a | b;
      2'b10: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk) alu_data <= alu8(alu_a, alu_b, alu_s, alu_cin) ^ (corrupt ? 8'h10 : 8'h00);

  // Whole-word reference: plain 16-bit arithmetic/logic on the operands
  task automatic ref16(input logic [2:0] o, input logic [15:0] a, b, input logic c,
                       output logic [15:0] r, output logic co);
    int unsigned s, ad;
    if (!o[2]) begin
      ad = (o[1:0] == 0) ? 0 : (o[1:0] == 1) ? b : (o[1:0] == 2) ? (32'hFFFF - b) : 32'hFFFF;
      s  = a + ad + c;
      r  = s[15:0];
      co = s[16];
    end else begin
      co = 1'b0;
      case ({o[0], c})
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~a;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge in IDLE; returns at the negedge where done is seen.
  // Inputs are scrambled after acceptance to show the latched copy is used.
  task automatic run_cmd(input logic [2:0] o, input logic [15:0] a, b, input logic c,
                         input bit pulse_busy, input bit corrupt_hi,
                         output logic [15:0] r, output logic co, output int lat,
                         output logic hicin, output int busy_bad);
    start = 1'b1; op = o; x = a; y = b; cin = c;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); x = 16'($urandom); y = 16'($urandom); cin = 1'($urandom);
    lat = 0; busy_bad = 0; hicin = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (done) begin lat = cyc; break; end
      if (!busy) busy_bad++;
      if (cyc == 2) begin
        hicin = alu_cin;
        if (pulse_busy) start = 1'b1;
        if (corrupt_hi) corrupt = 1'b1;
      end else begin
        start = 1'b0;
        corrupt = 1'b0;
      end
      @(posedge clk);
    end
    r = result; co = cout;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x, y;
    logic        cin, pulse;
    logic [15:0] er;
    logic        ec, ehc;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [15:0] r, er;
    logic co, ec, hc;
    int lat, bb, dcnt;

    vt[0] = '{3'b001, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1};
    vt[1] = '{3'b001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[2] = '{3'b010, 16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b1};
    vt[3] = '{3'b101, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 16'h0FF0, 1'b0, 1'b0};
    vt[4] = '{3'b100, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0};
    vt[5] = '{3'b100, 16'hF0F0, 16'hFF00, 1'b1, 1'b0, 16'hFFF0, 1'b0, 1'b1};
    vt[6] = '{3'b101, 16'hF0F0, 16'h1234, 1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b1};
    vt[7] = '{3'b000, 16'hFFFF, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[8] = '{3'b011, 16'h0005, 16'h9999, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b1};
    vt[9] = '{3'b110, 16'h1234, 16'h00FF, 1'b0, 1'b0, 16'h0034, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b1; op = 3'b001; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", {28'h0, cout, busy, done, 1'b0}, 32'h0);
    chk("rst_alu", {12'h0, alu_a, alu_b, alu_s, alu_cin}, 32'h0);
`ifdef ALU_SEQ_CHECK_EN
    chk("rst_err", 32'(err), 32'h0);
`endif
    rst = 1'b0; start = 1'b0;

    // Directed table, issued back-to-back
    for (int i = 0; i < 10; i++) begin
      run_cmd(vt[i].op, vt[i].x, vt[i].y, vt[i].cin, vt[i].pulse, 1'b0, r, co, lat, hc, bb);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].er));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vt[i].ec));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_busy", i), 32'(bb), 32'd0);
      chk($sformatf("vec%0d_hicin", i), 32'(hc), 32'(vt[i].ehc));
    end
    @(posedge clk); @(negedge clk);
    chk("idle_after_busy_start", {30'h0, busy, done}, 32'h0);

    // Randomized commands against the word-level model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o; logic [15:0] a, b; logic c;
      o = 3'($urandom); a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i % 5 == 0) a = 16'hFFFF;
      ref16(o, a, b, c, er, ec);
      run_cmd(o, a, b, c, 1'($urandom), 1'b0, r, co, lat, hc, bb);
      chk($sformatf("rnd%0d_result", i), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_cout", i), 32'(co), 32'(ec));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
    end

    // Reset while in HI: no done, outputs cleared, then a clean command
    start = 1'b1; op = 3'b001; x = 16'h1234; y = 16'h1111; cin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("hirst_busy", 32'(busy), 32'h0);
    chk("hirst_result", 32'(result), 32'h0);
    rst = 1'b0;
    dcnt = 0;
    repeat (5) begin @(negedge clk); if (done || busy) dcnt++; end
    chk("hirst_no_done", 32'(dcnt), 32'h0);
    run_cmd(3'b001, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, r, co, lat, hc, bb);
    chk("hirst_next_result", 32'(r), 32'h2345);
    chk("hirst_next_latency", 32'(lat), 32'd4);

`ifdef ALU_SEQ_CHECK_EN
    chk("err_clean", 32'(err), 32'h0);
    run_cmd(3'b001, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, r, co, lat, hc, bb);
    @(negedge clk);
    chk("err_set", 32'(err), 32'h1);
    run_cmd(3'b001, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, r, co, lat, hc, bb);
    chk("err_held", 32'(err), 32'h1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the attached 8-bit ALU.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  command strobe, sampled only in IDLE.
REQ-005 op  input  3  operation code, same encoding as the ALU S input.
REQ-006 x  input  16  operand A.
REQ-007 y  input  16  operand B.
REQ-008 cin  input  1  carry-in for arithmetic ops; logic sub-select for logic ops.
REQ-009 alu_a  output  8  byte operand A driven to the ALU.
REQ-010 alu_b  output  8  byte operand B driven to the ALU.
REQ-011 alu_s  output  3  op select driven to the ALU.
REQ-012 alu_cin  output  1  Cin driven to the ALU.
REQ-013 alu_data  input  8  registered ALU result, valid one cycle after issue.
REQ-014 result  output  16  assembled 16-bit result, held until the next done.
REQ-015 cout  output  1  16-bit carry-out for arithmetic ops; 0 for logic ops.
REQ-016 busy  output  1  high in states LO, HI and FIN.
REQ-017 done  output  1  one-cycle pulse when result and cout are updated.
REQ-018 err  output  1  sticky mismatch flag, present only when ALU_SEQ_CHECK_EN is defined (see REQ-036).

Function
REQ-019 FSM states SHALL be IDLE, LO, HI and FIN, with transitions IDLE->LO (start=1), LO->HI, HI->FIN and FIN->IDLE, each transition taken unconditionally on the next edge.
REQ-020 In IDLE, start=1 SHALL latch op, x, y and cin; start SHALL be ignored while busy=1.
REQ-021 In IDLE, alu_a, alu_b, alu_s and alu_cin SHALL all be driven to 0.
REQ-022 In LO, alu_a=x[7:0], alu_b=y[7:0] and alu_s=op SHALL be driven, with alu_cin=cin.
REQ-023 In HI, alu_a=x[15:8], alu_b=y[15:8] and alu_s=op SHALL be driven; on the HI->FIN edge, result[7:0]<=alu_data.
REQ-024 In HI, alu_cin SHALL be c8, the locally computed carry out of x[7:0]+addend[7:0]+cin, when op[2]=0, and SHALL be cin when op[2]=1.
REQ-025 The 16-bit addend SHALL be 0, y, ~y or 16'hFFFF for op[1:0] = 0, 1, 2 or 3 respectively, and cout SHALL be bit 16 of x+addend+cin.
REQ-026 For logic ops, {op[0],cin} SHALL select AND, OR, XOR or NOT-x for values 00, 01, 10 and 11 respectively, identically on both bytes, and cout SHALL be 0.
REQ-027 On the FIN->IDLE edge, result[15:8]<=alu_data and cout SHALL be updated, and done SHALL be high for exactly one cycle after that edge.
REQ-028 Latency SHALL be fixed: with start accepted at edge E0, done SHALL be high in the cycle following E3.
REQ-029 A new start SHALL be accepted in the same cycle that done is high (back-to-back, one command per 4 cycles).
REQ-030 The latched operands SHALL be used for the whole operation; changes on x, y, op or cin during busy SHALL have no effect.
REQ-031 cout SHALL be computed locally, because the ALU provides no usable carry output.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-operation, and any in-flight command SHALL be discarded.
REQ-033 Reset values SHALL be result=0, cout=0, busy=0, done=0, err=0, and alu_a, alu_b, alu_s and alu_cin all 0.
REQ-034 rst SHALL take priority over start in the same cycle.

Configuration
REQ-035 The feature SHALL be controlled by macro ALU_SEQ_CHECK_EN.
REQ-036 With ALU_SEQ_CHECK_EN defined, the block SHALL compute the expected byte for each issue and compare it with alu_data at the capture edges (HI->FIN, FIN->IDLE); any mismatch SHALL set err, which stays set until rst.
REQ-037 Without ALU_SEQ_CHECK_EN, no checker logic SHALL be built, the err port SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 ADD: op=001, cin=0, x=16'h00FF, y=16'h0001 -> result=16'h0100, cout=0, done exactly 4 edges after start.
REQ-039 ADD wrap: op=001, cin=0, x=16'hFFFF, y=16'h0001 -> result=16'h0000, cout=1; alu_cin=1 observed in HI.
REQ-040 SUB: op=010, cin=1, x=16'h1234, y=16'h0234 -> result=16'h1000, cout=1.
REQ-041 XOR: op=101, cin=0, x=16'hF0F0, y=16'hFF00 -> result=16'h0FF0, cout=0; start pulsed during busy -> ignored.
REQ-042 Reset in HI -> next cycle IDLE, busy=0, result=0, no done pulse; a following command completes normally.
REQ-043 With ALU_SEQ_CHECK_EN defined and the ALU model corrupting a high byte -> err=1 after FIN and held until rst.
